// File: rtl/chasy_pkg.sv
// Shared mode definitions for the watch control slice.
package chasy_pkg;
  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    CLOCK     = 2'd0,
    SETUP     = 2'd1,
    TIMER     = 2'd2,
    STOPWATCH = 2'd3
  } mode_t;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      CLOCK:   return SETUP;
      SETUP:   return TIMER;
      TIMER:   return STOPWATCH;
      default: return CLOCK;
    endcase
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/sec_counter.sv
// Saturating seconds counter; hit_o flags the tick that brings it to LIMIT.
module sec_counter #(
  parameter int LIMIT = 30,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  input  logic tick_i,
  output logic hit_o
);
  localparam logic [W-1:0] LIMIT_C = W'(LIMIT);
  localparam logic [W-1:0] LAST_C  = W'(LIMIT - 1);

  logic [W-1:0] count_q, count_d;

  // Held at zero while disabled so every enable starts a fresh count.
  always_comb begin
    count_d = count_q;
    hit_o   = 1'b0;
    if (clr_i || !en_i) begin
      count_d = '0;
    end else if (tick_i) begin
      hit_o = (count_q >= LAST_C);
      if (count_q != LIMIT_C) count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end
endmodule

// File: rtl/mode_ctrl.sv
// Watch mode controller: mode cycling, button routing, setup idle exit and
// timer-expiry alert with mode save/restore.
module mode_ctrl
  import chasy_pkg::*;
#(
  parameter int IDLE_SEC  = 30,
  parameter int ALERT_SEC = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick_1hz,
  input  logic              btn_mode,
  input  logic [2:0]        btn_in,
  input  logic              timer_done,
  output logic [MODE_W-1:0] mode,
  output logic [2:0]        btn_setup,
  output logic [2:0]        btn_timer,
  output logic [2:0]        btn_sw,
  output logic              setup_abort,
  output logic              blink,
  output logic              alert
);
  localparam int CNT_W = $clog2(max_int(IDLE_SEC, ALERT_SEC) + 1);

  mode_t      mode_q, mode_d, saved_q, saved_d;
  logic       alert_q, alert_d, blink_q, blink_d, abort_q, abort_d;
  logic [2:0] setup_q, setup_d, timer_q, timer_d, sw_q, sw_d;
  logic       any_btn, in_setup, idle_hit, alert_hit;

  assign any_btn  = btn_mode | (|btn_in);
  assign in_setup = (mode_q == SETUP) && !alert_q;

  sec_counter #(.LIMIT(IDLE_SEC), .W(CNT_W)) u_idle (
    .clock  (clock),
    .reset  (reset),
    .en_i   (in_setup),
    .clr_i  (any_btn),
    .tick_i (tick_1hz),
    .hit_o  (idle_hit)
  );

  sec_counter #(.LIMIT(ALERT_SEC), .W(CNT_W)) u_alert (
    .clock  (clock),
    .reset  (reset),
    .en_i   (alert_q),
    .clr_i  (timer_done),
    .tick_i (tick_1hz),
    .hit_o  (alert_hit)
  );

  always_comb begin
    mode_d  = mode_q;
    saved_d = saved_q;
    alert_d = alert_q;
    abort_d = 1'b0;
    setup_d = '0;
    timer_d = '0;
    sw_d    = '0;
    if (alert_q) begin
      // A repeated expiry only restarts the alert count; any button is swallowed.
      if (!timer_done && (any_btn || alert_hit)) begin
        alert_d = 1'b0;
        mode_d  = saved_q;
      end
    end else if (timer_done) begin
      alert_d = 1'b1;
      mode_d  = TIMER;
      saved_d = (mode_q == SETUP) ? CLOCK : mode_q;
      abort_d = (mode_q == SETUP);
    end else begin
      case (mode_q)
        SETUP:     setup_d = btn_in;
        TIMER:     timer_d = btn_in;
        STOPWATCH: sw_d    = btn_in;
        default:   ;
      endcase
      if (btn_mode) begin
        mode_d = next_mode(mode_q);
      end else if (idle_hit) begin
        mode_d  = CLOCK;
        abort_d = 1'b1;
      end
    end
    // Blink phase only advances while already in setup and is zero outside it.
    blink_d = ((mode_d == SETUP) && !alert_d) ? (blink_q ^ (tick_1hz & in_setup)) : 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q  <= CLOCK;
      saved_q <= CLOCK;
      alert_q <= 1'b0;
      blink_q <= 1'b0;
      abort_q <= 1'b0;
      setup_q <= '0;
      timer_q <= '0;
      sw_q    <= '0;
    end else begin
      mode_q  <= mode_d;
      saved_q <= saved_d;
      alert_q <= alert_d;
      blink_q <= blink_d;
      abort_q <= abort_d;
      setup_q <= setup_d;
      timer_q <= timer_d;
      sw_q    <= sw_d;
    end
  end

  assign mode        = mode_q;
  assign alert       = alert_q;
  assign blink       = blink_q;
  assign setup_abort = abort_q;
  assign btn_setup   = setup_q;
  assign btn_timer   = timer_q;
  assign btn_sw      = sw_q;
endmodule

// File: tb/tb_mode_ctrl.sv
// Bench for mode_ctrl: directed scenarios plus randomized traffic against a
// behavioural model of the mode/alert rules.
module tb_mode_ctrl;
  localparam int IDLE  = 3;
  localparam int ALRT  = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0, btn_mode = 1'b0, timer_done = 1'b0;
  logic [2:0] btn_in = 3'b000;
  logic [1:0] mode;
  logic [2:0] btn_setup, btn_timer, btn_sw;
  logic       setup_abort, blink, alert;

  int checks = 0;
  int errors = 0;

  // Model state
  int         m_mode, m_saved, m_idle, m_acnt;
  bit         m_alert, m_blink, m_abort, m_btn, m_was;
  logic [2:0] m_route [3];

  mode_ctrl #(.IDLE_SEC(IDLE), .ALERT_SEC(ALRT)) dut (
    .clock(clock), .reset(reset), .tick_1hz(tick_1hz), .btn_mode(btn_mode),
    .btn_in(btn_in), .timer_done(timer_done), .mode(mode), .btn_setup(btn_setup),
    .btn_timer(btn_timer), .btn_sw(btn_sw), .setup_abort(setup_abort),
    .blink(blink), .alert(alert)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one step per clock edge, reset clears everything.
  initial begin
    m_mode = 0; m_saved = 0; m_idle = 0; m_acnt = 0;
    m_alert = 0; m_blink = 0; m_abort = 0;
    m_route = '{3'b0, 3'b0, 3'b0};
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        m_mode = 0; m_saved = 0; m_idle = 0; m_acnt = 0;
        m_alert = 0; m_blink = 0; m_abort = 0;
        m_route = '{3'b0, 3'b0, 3'b0};
      end else begin
        m_btn = btn_mode || (btn_in != 3'b000);
        m_was = (m_mode == 1) && !m_alert;
        m_abort = 0;
        m_route = '{3'b0, 3'b0, 3'b0};
        if (m_alert) begin
          if (timer_done) m_acnt = 0;
          else if (m_btn) begin
            m_alert = 0; m_mode = m_saved; m_acnt = 0;
          end else if (tick_1hz) begin
            m_acnt++;
            if (m_acnt >= ALRT) begin
              m_alert = 0; m_mode = m_saved; m_acnt = 0;
            end
          end
        end else if (timer_done) begin
          m_saved = (m_mode == 1) ? 0 : m_mode;
          m_abort = (m_mode == 1);
          m_mode  = 2;
          m_alert = 1;
          m_acnt  = 0;
        end else begin
          if (m_mode != 0) m_route[m_mode-1] = btn_in;
          if (btn_mode) m_mode = (m_mode + 1) % 4;
          else if (m_mode == 1) begin
            if (m_btn) m_idle = 0;
            else if (tick_1hz) begin
              m_idle++;
              if (m_idle >= IDLE) begin
                m_mode = 0; m_abort = 1;
              end
            end
          end
        end
        if (!(m_mode == 1 && !m_alert)) begin
          m_idle = 0; m_blink = 0;
        end else if (m_was && tick_1hz) m_blink = !m_blink;
      end
    end
  end

  // Compare process on the inactive edge.
  initial forever begin
    @(negedge clock);
    chk("mode", 32'(mode), 32'(m_mode));
    chk("alert", 32'(alert), 32'(m_alert));
    chk("blink", 32'(blink), 32'(m_blink));
    chk("setup_abort", 32'(setup_abort), 32'(m_abort));
    chk("btn_setup", 32'(btn_setup), 32'(m_route[0]));
    chk("btn_timer", 32'(btn_timer), 32'(m_route[1]));
    chk("btn_sw", 32'(btn_sw), 32'(m_route[2]));
  end

  // Apply one cycle of inputs; returns just after the edge that samples them.
  task automatic step(input logic t, input logic bm, input logic [2:0] bi, input logic td);
    tick_1hz = t; btn_mode = bm; btn_in = bi; timer_done = td;
    @(posedge clock); #1;
    tick_1hz = 0; btn_mode = 0; btn_in = 3'b000; timer_done = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mode"}, 32'(mode), 32'd0);
    chk({tag, "_alert"}, 32'(alert), 32'd0);
    chk({tag, "_blink"}, 32'(blink), 32'd0);
    chk({tag, "_abort"}, 32'(setup_abort), 32'd0);
    chk({tag, "_routes"}, 32'({btn_setup, btn_timer, btn_sw}), 32'd0);
  endtask

  initial begin
    logic       t, bm, td;
    logic [2:0] bi;
    #1 reset = 1'b0;
    #2 chk_reset_vals("rst");
    @(posedge clock); @(posedge clock); #1 reset = 1'b1;

    // Mode cycling and stopwatch routing
    step(0, 1, 0, 0); chk("cyc1", 32'(mode), 1);
    step(0, 1, 0, 0); chk("cyc2", 32'(mode), 2);
    step(0, 1, 0, 0); chk("cyc3", 32'(mode), 3);
    step(0, 0, 3'b010, 0);
    chk("sw_route", 32'(btn_sw), 32'b010);
    chk("sw_other", 32'({btn_setup, btn_timer}), 0);
    step(0, 0, 0, 0); chk("sw_onecycle", 32'(btn_sw), 0);
    step(0, 1, 0, 0); chk("cyc0", 32'(mode), 0);

    // Setup idle exit
    step(0, 1, 0, 0);
    step(1, 0, 0, 0); chk("blink_on", 32'(blink), 1);
    step(1, 0, 0, 0); chk("blink_off", 32'(blink), 0);
    step(1, 0, 0, 0);
    chk("idle_exit", 32'(mode), 0); chk("idle_abort", 32'(setup_abort), 1);
    step(0, 0, 0, 0); chk("abort_1cyc", 32'(setup_abort), 0);

    // Button in setup restarts the idle count
    step(0, 1, 0, 0);
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 0, 3'b001, 0); chk("setup_route", 32'(btn_setup), 1);
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    chk("idle_hold", 32'(mode), 1);
    step(1, 0, 0, 0); chk("idle_exit2", 32'(mode), 0);

    // Alert from stopwatch, auto release
    step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
    step(0, 0, 0, 1); chk("alert_mode", 32'(mode), 2); chk("alert_set", 32'(alert), 1);
    step(1, 0, 0, 0); chk("alert_hold", 32'(alert), 1);
    step(1, 0, 0, 0); chk("alert_rel", 32'(alert), 0); chk("alert_restore", 32'(mode), 3);

    // Alert from setup saves CLOCK and aborts setup
    step(0, 1, 0, 0); step(0, 1, 0, 0);
    step(0, 0, 0, 1); chk("setup_alert_abort", 32'(setup_abort), 1);
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    chk("setup_alert_restore", 32'(mode), 0);

    // Button cancels alert and is consumed
    step(0, 0, 0, 1);
    step(0, 0, 3'b001, 0);
    chk("cancel_alert", 32'(alert), 0); chk("cancel_mode", 32'(mode), 0);
    chk("cancel_noroute", 32'(btn_timer), 0);
    step(0, 0, 0, 0); chk("cancel_noroute2", 32'(btn_timer), 0);

    // timer_done beats btn_mode
    step(0, 1, 0, 1); chk("td_wins", 32'(mode), 2);
    step(0, 1, 0, 0); chk("bm_consumed", 32'(mode), 0);

    // Reset during alert with a tick already counted in setup
    step(0, 1, 0, 0); step(1, 0, 0, 0);
    step(0, 0, 0, 1); chk("pre_rst_abort", 32'(setup_abort), 1);
    reset = 1'b0;
    #1 chk_reset_vals("async");
    @(posedge clock); @(posedge clock); #2 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0); chk_reset_vals("post_rst");
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      t  = ($urandom_range(0, 2) == 0);
      bm = ($urandom_range(0, 9) == 0);
      bi = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      td = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b0; #2 reset = 1'b1;
      end
      step(t, bm, bi, td);
    end

    @(negedge clock); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mode_ctrl.md
MODE_CTRL -- requirements
Module: mode_ctrl

Interface
REQ-001 Parameter: IDLE_SEC, default 30; seconds without a button press in SETUP before automatic exit to CLOCK.
REQ-002 Parameter: ALERT_SEC, default 10; seconds the timer-expiry alert is held before automatic release.
REQ-003 Port: clock  in  1  system clock; the block has one clock.
REQ-004 Port: reset  in  1  reset, asynchronous, active-low.
REQ-005 Port: tick_1hz  in  1  one-cycle pulse per second, synchronous to clock.
REQ-006 Port: btn_mode  in  1  debounced one-cycle mode-button pulse.
REQ-007 Port: btn_in  in  3  debounced one-cycle pulses from the three function buttons.
REQ-008 Port: timer_done  in  1  one-cycle pulse when the countdown timer expires.
REQ-009 Port: mode  out  2  active display/control mode: 0 CLOCK, 1 SETUP, 2 TIMER, 3 STOPWATCH.
REQ-010 Port: btn_setup, btn_timer, btn_sw  out  3 each  btn_in routed to the owning function.
REQ-011 Port: setup_abort  out  1  one-cycle pulse; the setup function discards uncommitted edits.
REQ-012 Port: blink  out  1  digit-blink phase for the setup display.
REQ-013 Port: alert  out  1  high while the timer-expiry alert is active.

Function
REQ-014 The mode FSM SHALL have states CLOCK, SETUP, TIMER and STOPWATCH, encoded as in REQ-009, plus a separate alert flag and a 2-bit saved-mode register.
REQ-015 With alert low, a btn_mode pulse SHALL advance mode cyclically 0->1->2->3->0 on the next clock edge.
REQ-016 With alert low, a btn_in pulse SHALL appear on the output group owned by the current mode one cycle later: SETUP->btn_setup, TIMER->btn_timer, STOPWATCH->btn_sw. It SHALL be dropped in CLOCK.
REQ-017 Routed outputs SHALL be registered and one cycle wide, and at most one output group SHALL be nonzero in any cycle.
REQ-018 In SETUP, an idle counter SHALL increment on tick_1hz and clear on any btn_in or btn_mode pulse; a button pulse wins over a coincident tick.
REQ-019 When the idle counter reaches IDLE_SEC, the block SHALL go to CLOCK and pulse setup_abort in the same cycle mode changes. The idle counter SHALL clear on every entry to SETUP.
REQ-020 On timer_done with alert low, the block SHALL set alert and force mode to TIMER on the next edge. It SHALL save the prior mode, or save CLOCK if the prior mode was SETUP, and pulse setup_abort when leaving SETUP.
REQ-021 While alert is high, an alert counter SHALL count tick_1hz. Alert SHALL clear on reaching ALERT_SEC or on any btn_in or btn_mode pulse, and mode SHALL restore to the saved mode on the edge alert clears.
REQ-022 The pulse that cancels an alert SHALL be consumed: it is not routed and does not advance mode.
REQ-023 A timer_done pulse while alert is high SHALL restart the alert counter only; the saved mode is unchanged.
REQ-024 If timer_done and btn_mode coincide, timer_done SHALL win and btn_mode SHALL be dropped.
REQ-025 blink SHALL toggle on each tick_1hz while mode is SETUP and alert is low, and SHALL be 0 otherwise.
REQ-026 Counter widths SHALL be $clog2(max(IDLE_SEC, ALERT_SEC)+1), and the counters SHALL saturate, never wrap.

Reset
REQ-027 On reset low, asynchronously: mode=CLOCK, saved mode=CLOCK, alert=0, blink=0, setup_abort=0, all routed button outputs=0, both counters=0.
REQ-028 Reset asserted mid-alert or mid-SETUP SHALL discard all state. No setup_abort pulse SHALL be emitted after reset release.

Structure
REQ-029 A shared package chasy_pkg SHALL hold the mode_t enum (CLOCK, SETUP, TIMER, STOPWATCH) and the 2-bit mode width constant.
REQ-030 One sub-module, sec_counter (tick-enabled counter with clear, saturation and terminal-count flag, parameterised limit), SHALL be instantiated twice: idle and alert.

Verification (IDLE_SEC=3, ALERT_SEC=2)
REQ-031 Four btn_mode pulses from reset -> mode 1,2,3,0. In mode 3, btn_in=3'b010 -> btn_sw=3'b010 one cycle later, btn_setup=btn_timer=0.
REQ-032 Enter SETUP, then 3 ticks with no buttons -> mode=0 and a single-cycle setup_abort. Repeat with btn_in pulse after tick 2 -> still SETUP after tick 4; exit after tick 5.
REQ-033 Mode 3, timer_done -> mode=2, alert=1. After 2 ticks -> alert=0, mode=3. Repeat from SETUP -> setup_abort pulse, restore to mode 0.
REQ-034 During alert, btn_in=3'b001 -> alert clears, mode restores, btn_timer stays 0. timer_done coincident with btn_mode in mode 0 -> mode=2, not 1.
REQ-035 Assert reset during alert, with 1 tick counted in SETUP -> all outputs at REQ-027 values immediately. After release, mode=0, with no setup_abort and no blink.
